demux_1x8: RTL and testbench

DEMUX_1X8 -- requirements
Module: demux_1x8

---
 rtl/demux_pkg.sv | 12 +
 rtl/demux_if.sv | 20 ++
 rtl/demux_decode.sv | 26 ++
 rtl/demux_1x8.sv | 66 ++++++
 tb/tb_demux_1x8.sv | 136 +++++++++++++
 5 files changed

// File: rtl/demux_pkg.sv
// Shared constants and helpers for the 1-to-8 demultiplexer.
package demux_pkg;

  localparam int NUM_OUT = 8;
  localparam int SEL_W   = 3;

  function automatic logic [NUM_OUT-1:0] onehot(input logic [SEL_W-1:0] sel);
    onehot      = '0;
    onehot[sel] = 1'b1;
  endfunction

endpackage

// File: rtl/demux_if.sv
// Bus bundle for demux_1x8: data/select/enable in, eight routed outputs plus valid out.
interface demux_if #(
  parameter int DATA_W = 1
);
  logic              en;
  logic [DATA_W-1:0] D;
  logic [2:0]        S;
  logic [DATA_W-1:0] Y0, Y1, Y2, Y3, Y4, Y5, Y6, Y7;
  logic              y_valid;

  modport master (
    output en, D, S,
    input  Y0, Y1, Y2, Y3, Y4, Y5, Y6, Y7, y_valid
  );

  modport slave (
    input  en, D, S,
    output Y0, Y1, Y2, Y3, Y4, Y5, Y6, Y7, y_valid
  );
endinterface

// File: rtl/demux_decode.sv
// Combinational 3-to-8 one-hot decode; each output is data ANDed with its select line.
module demux_decode
  import demux_pkg::*;
#(
  parameter int DATA_W = 1
) (
  input  logic [DATA_W-1:0]              d,
  input  logic [SEL_W-1:0]               sel,
  output logic [NUM_OUT-1:0][DATA_W-1:0] y
);

  logic [NUM_OUT-1:0] sel_oh;

  assign sel_oh = onehot(sel);

  always_comb begin
    y = '0;
    // Unknown select or data routes nothing rather than smearing X onto all outputs.
    if (!$isunknown({sel, d})) begin
      for (int k = 0; k < NUM_OUT; k++) begin
        y[k] = d & {DATA_W{sel_oh[k]}};
      end
    end
  end

endmodule

// File: rtl/demux_1x8.sv
// 1-to-8 demultiplexer: decode sub-module plus optional enabled output register and valid flag.
module demux_1x8
  import demux_pkg::*;
#(
  parameter int DATA_W  = 1,
  parameter int REG_OUT = 1
) (
  input logic     clk,
  input logic     rst_n,
  demux_if.slave  bus
);

  logic [NUM_OUT-1:0][DATA_W-1:0] dec_y;
  logic [NUM_OUT-1:0][DATA_W-1:0] y_out;
  logic                           valid_out;

  demux_decode #(
    .DATA_W (DATA_W)
  ) u_decode (
    .d   (bus.D),
    .sel (bus.S),
    .y   (dec_y)
  );

  if (REG_OUT != 0) begin : g_reg
    logic [NUM_OUT-1:0][DATA_W-1:0] y_d, y_q;
    logic                           valid_d, valid_q;

    always_comb begin
      y_d     = y_q;
      valid_d = valid_q;
      if (bus.en) begin
        y_d     = dec_y;
        valid_d = 1'b1;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        y_q     <= '0;
        valid_q <= 1'b0;
      end else begin
        y_q     <= y_d;
        valid_q <= valid_d;
      end
    end

    assign y_out     = y_q;
    assign valid_out = valid_q;
  end else begin : g_comb
    // No state here: valid simply mirrors reset so downstream sees 0 while held in reset.
    assign y_out     = dec_y;
    assign valid_out = rst_n;
  end

  assign bus.Y0      = y_out[0];
  assign bus.Y1      = y_out[1];
  assign bus.Y2      = y_out[2];
  assign bus.Y3      = y_out[3];
  assign bus.Y4      = y_out[4];
  assign bus.Y5      = y_out[5];
  assign bus.Y6      = y_out[6];
  assign bus.Y7      = y_out[7];
  assign bus.y_valid = valid_out;

endmodule

// File: tb/tb_demux_1x8.sv
// Directed plus random bench for demux_1x8 (registered and combinational builds) against a behavioural model.
module tb_demux_1x8;

  localparam int W = 8;

  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  demux_if #(.DATA_W(W)) ifr ();
  demux_if #(.DATA_W(W)) ifc ();

  demux_1x8 #(.DATA_W(W), .REG_OUT(1)) dut_reg (.clk(clk), .rst_n(rst_n), .bus(ifr));
  demux_1x8 #(.DATA_W(W), .REG_OUT(0)) dut_comb (.clk(clk), .rst_n(rst_n), .bus(ifc));

  assign ifc.en = ifr.en;
  assign ifc.D  = ifr.D;
  assign ifc.S  = ifr.S;

  logic [W-1:0] act_r [8];
  logic [W-1:0] act_c [8];
  assign act_r[0] = ifr.Y0; assign act_r[1] = ifr.Y1; assign act_r[2] = ifr.Y2; assign act_r[3] = ifr.Y3;
  assign act_r[4] = ifr.Y4; assign act_r[5] = ifr.Y5; assign act_r[6] = ifr.Y6; assign act_r[7] = ifr.Y7;
  assign act_c[0] = ifc.Y0; assign act_c[1] = ifc.Y1; assign act_c[2] = ifc.Y2; assign act_c[3] = ifc.Y3;
  assign act_c[4] = ifc.Y4; assign act_c[5] = ifc.Y5; assign act_c[6] = ifc.Y6; assign act_c[7] = ifc.Y7;

  // Reference model: what the registered outputs should hold right now.
  logic [W-1:0] exp_y [8];
  logic         exp_v;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] route(input logic [W-1:0] d, input int s, input int k);
    return (k == s) ? d : '0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 8; k++) exp_y[k] = '0;
    exp_v = 1'b0;
  endtask

  task automatic check1(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic check_reg(input string tag);
    for (int k = 0; k < 8; k++) check1($sformatf("%s_reg_Y%0d", tag, k), act_r[k], exp_y[k]);
    check1($sformatf("%s_reg_valid", tag), {{(W-1){1'b0}}, ifr.y_valid}, {{(W-1){1'b0}}, exp_v});
  endtask

  task automatic check_comb(input string tag);
    for (int k = 0; k < 8; k++)
      check1($sformatf("%s_comb_Y%0d", tag, k), act_c[k], route(ifr.D, int'(ifr.S), k));
    check1($sformatf("%s_comb_valid", tag), {{(W-1){1'b0}}, ifc.y_valid}, {{(W-1){1'b0}}, rst_n});
  endtask

  // One rising edge; model updates from the inputs that were stable across it.
  task automatic step(input string tag);
    @(posedge clk);
    if (rst_n && ifr.en) begin
      for (int k = 0; k < 8; k++) exp_y[k] = route(ifr.D, int'(ifr.S), k);
      exp_v = 1'b1;
    end
    #1;
    check_reg(tag);
  endtask

  task automatic drive(input logic en, input logic [W-1:0] d, input logic [2:0] s);
    ifr.en = en;
    ifr.D  = d;
    ifr.S  = s;
    #1;
    check_comb("drv");
  endtask

  initial begin
    rst_n = 1'b0;
    model_reset();
    drive(1'b0, 8'h01, 3'd5);
    #2;
    check_reg("reset");
    @(posedge clk); #1;
    check_reg("reset_clk");

    rst_n = 1'b1;
    drive(1'b1, 8'h01, 3'd5);
    step("first_edge");

    for (int s = 0; s < 8; s++) begin
      drive(1'b1, 8'h01, 3'(s));
      step($sformatf("sweep%0d", s));
    end

    drive(1'b1, 8'h00, 3'd3);
    step("data_zero");

    drive(1'b1, 8'h01, 3'd2);
    step("hold_load");
    drive(1'b0, 8'h01, 3'd6);
    step("hold1");
    step("hold2");

    drive(1'b1, 8'h01, 3'd7);
    step("pre_async");
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_reg("async_rst");
    check_comb("async_rst");
    #2;
    rst_n = 1'b1;
    drive(1'b1, 8'hA5, 3'd4);
    step("width_fresh");

    drive(1'b1, 8'h3C, 3'd0);
    step("sel0");
    drive(1'b1, 8'hC3, 3'd7);
    step("sel7");

    for (int i = 0; i < 60; i++) begin
      drive(($urandom_range(0, 3) != 0), 8'($urandom), 3'($urandom_range(0, 7)));
      step("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
